pp_merger: RTL and testbench

- Downstream stage of the ping-pong splitter: takes its two AXI-Stream outputs and merges them back into one ordered stream.
- Consumes exactly PP_GROUP whole packets from input 1, then PP_GROUP whole packets from input 2, and repeats.
- Restores the original packet order before the stream reaches the sink or DMA.
- Single registered output stage; full throughput (one beat per clock) when the sink is always ready.

---
 rtl/pp_merger.sv | 115 +++++++++++
 tb/tb_pp_merger.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_merger.sv
// Ping-pong merger: drains PP_GROUP whole packets from input 1, then PP_GROUP
// from input 2, and repeats, restoring the original packet order on one stream.
module pp_merger #(
  parameter int DW = 512
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [31:0]     PP_GROUP,
  input  logic [DW-1:0]   AXIS_IN1_TDATA,
  input  logic            AXIS_IN1_TVALID,
  output logic            AXIS_IN1_TREADY,
  input  logic [DW/8-1:0] AXIS_IN1_TKEEP,
  input  logic            AXIS_IN1_TLAST,
  input  logic [DW-1:0]   AXIS_IN2_TDATA,
  input  logic            AXIS_IN2_TVALID,
  output logic            AXIS_IN2_TREADY,
  input  logic [DW/8-1:0] AXIS_IN2_TKEEP,
  input  logic            AXIS_IN2_TLAST,
  output logic [DW-1:0]   AXIS_OUT_TDATA,
  output logic            AXIS_OUT_TVALID,
  input  logic            AXIS_OUT_TREADY,
  output logic [DW/8-1:0] AXIS_OUT_TKEEP,
  output logic            AXIS_OUT_TLAST,
  output logic [31:0]     PKT_COUNT
);

  typedef enum logic {SEL1, SEL2} state_t;

  state_t            state_q;
  logic [31:0]       grpCnt_q;
  logic [31:0]       target_q;
  logic              needSample_q;
  logic              outValid_q;
  logic              outLast_q;
  logic [DW-1:0]     outData_q;
  logic [DW/8-1:0]   outKeep_q;
  logic [31:0]       pktCount_q;

  logic              loadOk;
  logic              accept;
  logic              selLast;
  logic [DW-1:0]     selData;
  logic [DW/8-1:0]   selKeep;
  logic [31:0]       groupEff;
  logic [31:0]       effTarget;
  logic [31:0]       grpCnt_d;
  logic [31:0]       pktCount_d;

  assign loadOk          = !outValid_q || AXIS_OUT_TREADY;
  assign AXIS_IN1_TREADY = (state_q == SEL1) && loadOk;
  assign AXIS_IN2_TREADY = (state_q == SEL2) && loadOk;

  assign accept  = (state_q == SEL1) ? (AXIS_IN1_TVALID && AXIS_IN1_TREADY)
                                     : (AXIS_IN2_TVALID && AXIS_IN2_TREADY);
  assign selData = (state_q == SEL1) ? AXIS_IN1_TDATA : AXIS_IN2_TDATA;
  assign selKeep = (state_q == SEL1) ? AXIS_IN1_TKEEP : AXIS_IN2_TKEEP;
  assign selLast = (state_q == SEL1) ? AXIS_IN1_TLAST : AXIS_IN2_TLAST;

  // The target is sampled on the first edge after reset instead of being
  // loaded asynchronously from a port, so the reset value stays constant.
  assign groupEff   = (PP_GROUP == 32'd0) ? 32'd1 : PP_GROUP;
  assign effTarget  = needSample_q ? groupEff : target_q;
  assign grpCnt_d   = grpCnt_q + 32'd1;
  assign pktCount_d = pktCount_q + 32'd1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= SEL1;
      grpCnt_q     <= '0;
      target_q     <= 32'd1;
      needSample_q <= 1'b1;
      outValid_q   <= 1'b0;
      outLast_q    <= 1'b0;
      outData_q    <= '0;
      outKeep_q    <= '0;
      pktCount_q   <= '0;
    end else begin
      if (accept) begin
        outData_q  <= selData;
        outKeep_q  <= selKeep;
        outLast_q  <= selLast;
        outValid_q <= 1'b1;
      end else if (loadOk) begin
        outValid_q <= 1'b0;
      end

      if (outValid_q && AXIS_OUT_TREADY && outLast_q) begin
        pktCount_q <= pktCount_d;
      end

      if (needSample_q) begin
        target_q     <= groupEff;
        needSample_q <= 1'b0;
      end

      // Sides only switch on a packet boundary that completes the group.
      if (accept && selLast) begin
        if (grpCnt_d == effTarget) begin
          grpCnt_q <= '0;
          state_q  <= (state_q == SEL1) ? SEL2 : SEL1;
          target_q <= groupEff;
        end else begin
          grpCnt_q <= grpCnt_d;
        end
      end
    end
  end

  assign AXIS_OUT_TDATA  = outData_q;
  assign AXIS_OUT_TVALID = outValid_q;
  assign AXIS_OUT_TKEEP  = outKeep_q;
  assign AXIS_OUT_TLAST  = outLast_q;
  assign PKT_COUNT       = pktCount_q;

endmodule

// File: tb/tb_pp_merger.sv
// Directed bench for pp_merger: two packet sources feed the merger and each
// scenario task checks the merged order, stalls, idling and reset behaviour.
module tb_pp_merger;

  localparam int DW = 32;
  localparam int KW = DW / 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic [31:0]   ppGroup;
  logic [DW-1:0] in1Data, in2Data, outData;
  logic [KW-1:0] in1Keep, in2Keep, outKeep;
  logic          in1Valid, in1Ready, in1Last;
  logic          in2Valid, in2Ready, in2Last;
  logic          outValid, outReady, outLast;
  logic [31:0]   pktCount;

  pp_merger #(.DW(DW)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .PP_GROUP        (ppGroup),
    .AXIS_IN1_TDATA  (in1Data),
    .AXIS_IN1_TVALID (in1Valid),
    .AXIS_IN1_TREADY (in1Ready),
    .AXIS_IN1_TKEEP  (in1Keep),
    .AXIS_IN1_TLAST  (in1Last),
    .AXIS_IN2_TDATA  (in2Data),
    .AXIS_IN2_TVALID (in2Valid),
    .AXIS_IN2_TREADY (in2Ready),
    .AXIS_IN2_TKEEP  (in2Keep),
    .AXIS_IN2_TLAST  (in2Last),
    .AXIS_OUT_TDATA  (outData),
    .AXIS_OUT_TVALID (outValid),
    .AXIS_OUT_TREADY (outReady),
    .AXIS_OUT_TKEEP  (outKeep),
    .AXIS_OUT_TLAST  (outLast),
    .PKT_COUNT       (pktCount)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int  pktLen;
  int  in1Pkt, in1Beat, in1Max, in2Pkt, in2Beat, in2Max;
  bit  in1En, in2En;
  int  cycleNo;
  bit  bothReady, stallReady, stabErr, r2Seen, ovSeen, prevStall;
  int  stallCnt;
  logic [36:0] prevOut;
  logic [36:0] outQ[$];
  int          outCyc[$];

  // Beat encoding: {last, keep, side, pkt, 16'h0, beat}.
  function automatic logic [36:0] mk(int side, int pkt, int beat);
    logic [31:0] d;
    logic [3:0]  k;
    d = {4'(side), 4'(pkt), 16'h0000, 8'(beat)};
    k = 4'(1 << beat);
    return {(beat == pktLen - 1), k, d};
  endfunction

  task automatic drive();
    {in1Last, in1Keep, in1Data} = mk(1, in1Pkt, in1Beat);
    {in2Last, in2Keep, in2Data} = mk(2, in2Pkt, in2Beat);
    in1Valid = in1En && (in1Pkt < in1Max);
    in2Valid = in2En && (in2Pkt < in2Max);
  endtask

  task automatic doReset();
    resetn    = 1'b0;
    outReady  = 1'b1;
    in1Pkt = 0; in1Beat = 0; in1Max = 1000;
    in2Pkt = 0; in2Beat = 0; in2Max = 1000;
    drive();
    @(posedge clk);
    #1;
    resetn     = 1'b1;
    cycleNo    = 0;
    bothReady  = 0; stallReady = 0; stabErr = 0; r2Seen = 0; ovSeen = 0;
    prevStall  = 0; stallCnt = 0;
    outQ.delete();
    outCyc.delete();
  endtask

  // One clock: sample mid-cycle, record handshakes, then advance the sources.
  task automatic step();
    logic r1, r2, ov, ordy, acc1, acc2;
    logic [36:0] o;
    #4;
    r1 = in1Ready; r2 = in2Ready; ov = outValid; ordy = outReady;
    o = {outLast, outKeep, outData};
    acc1 = r1 && in1Valid;
    acc2 = r2 && in2Valid;
    if (r1 && r2) bothReady = 1;
    if (r2) r2Seen = 1;
    if (ov) ovSeen = 1;
    if (ov && !ordy && (r1 || r2)) stallReady = 1;
    if (prevStall && (!ov || o !== prevOut)) stabErr = 1;
    prevStall = ov && !ordy;
    prevOut   = o;
    if (ov && !ordy) stallCnt++;
    if (ov && ordy) begin
      outQ.push_back(o);
      outCyc.push_back(cycleNo);
    end
    @(posedge clk);
    #1;
    cycleNo++;
    if (acc1) begin
      if (in1Beat == pktLen - 1) begin in1Beat = 0; in1Pkt++; end
      else in1Beat++;
    end
    if (acc2) begin
      if (in2Beat == pktLen - 1) begin in2Beat = 0; in2Pkt++; end
      else in2Beat++;
    end
    drive();
  endtask

  task automatic test_reset();
    ppGroup = 32'd1; pktLen = 2; in1En = 1; in2En = 1;
    in1Pkt = 0; in1Beat = 0; in1Max = 1000;
    in2Pkt = 0; in2Beat = 0; in2Max = 1000;
    outReady = 1'b1;
    drive();
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1;
    total++; if (outValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", outValid); end
    total++; if (outData !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", outData); end
    total++; if (outKeep !== '0) begin bad++; $display("FAIL reset_keep got=%h exp=0", outKeep); end
    total++; if (outLast !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", outLast); end
    total++; if (pktCount !== 32'd0) begin bad++; $display("FAIL reset_pktcount got=%0d exp=0", pktCount); end
    total++; if ({in1Ready, in2Ready} !== 2'b10) begin bad++; $display("FAIL reset_ready got=%b exp=10", {in1Ready, in2Ready}); end
  endtask

  task automatic test_group_order();
    int sides[8] = '{1, 1, 2, 2, 1, 1, 2, 2};
    int pkts[8]  = '{0, 1, 0, 1, 2, 3, 2, 3};
    ppGroup = 32'd2; pktLen = 4; in1En = 1; in2En = 1;
    doReset();
    for (int i = 0; i < 33; i++) step();
    total++; if (outQ.size() !== 32) begin bad++; $display("FAIL order_count got=%0d exp=32", outQ.size()); end
    for (int k = 0; k < outQ.size() && k < 32; k++) begin
      total++;
      if (outQ[k] !== mk(sides[k/4], pkts[k/4], k % 4)) begin
        bad++; $display("FAIL order_beat%0d got=%h exp=%h", k, outQ[k], mk(sides[k/4], pkts[k/4], k % 4));
      end
    end
    if (outCyc.size() >= 32) begin
      total++; if (outCyc[0] !== 1) begin bad++; $display("FAIL order_latency got=%0d exp=1", outCyc[0]); end
      total++; if (outCyc[31] !== 32) begin bad++; $display("FAIL order_throughput got=%0d exp=32", outCyc[31]); end
    end
    total++; if (pktCount !== 32'd8) begin bad++; $display("FAIL order_pktcount got=%0d exp=8", pktCount); end
  endtask

  task automatic test_alternation();
    ppGroup = 32'd0; pktLen = 1; in1En = 1; in2En = 1;
    doReset();
    for (int i = 0; i < 9; i++) step();
    total++; if (outQ.size() !== 8) begin bad++; $display("FAIL alt_count got=%0d exp=8", outQ.size()); end
    for (int k = 0; k < outQ.size() && k < 8; k++) begin
      total++;
      if (outQ[k] !== mk((k % 2) + 1, k / 2, 0)) begin
        bad++; $display("FAIL alt_beat%0d got=%h exp=%h", k, outQ[k], mk((k % 2) + 1, k / 2, 0));
      end
    end
    total++; if (bothReady !== 1'b0) begin bad++; $display("FAIL alt_both_ready got=%b exp=0", bothReady); end
  endtask

  task automatic test_stall();
    bit pat[14] = '{1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 1, 1, 1, 1};
    ppGroup = 32'd1; pktLen = 3; in1En = 1; in2En = 0;
    doReset();
    in1Max = 1;
    drive();
    for (int i = 0; i < 14; i++) begin
      outReady = pat[i];
      step();
    end
    total++; if (outQ.size() !== 3) begin bad++; $display("FAIL stall_count got=%0d exp=3", outQ.size()); end
    for (int k = 0; k < outQ.size() && k < 3; k++) begin
      total++;
      if (outQ[k] !== mk(1, 0, k)) begin bad++; $display("FAIL stall_beat%0d got=%h exp=%h", k, outQ[k], mk(1, 0, k)); end
    end
    total++; if (stabErr !== 1'b0) begin bad++; $display("FAIL stall_stable got=%b exp=0", stabErr); end
    total++; if (stallReady !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b exp=0", stallReady); end
    total++; if (stallCnt !== 3) begin bad++; $display("FAIL stall_cycles got=%0d exp=3", stallCnt); end
  endtask

  task automatic test_idle_side();
    ppGroup = 32'd1; pktLen = 2; in1En = 0; in2En = 1;
    doReset();
    for (int i = 0; i < 20; i++) step();
    total++; if (r2Seen !== 1'b0) begin bad++; $display("FAIL idle_in2_ready got=%b exp=0", r2Seen); end
    total++; if (ovSeen !== 1'b0) begin bad++; $display("FAIL idle_out_valid got=%b exp=0", ovSeen); end
    in1En = 1;
    drive();
    for (int i = 0; i < 6; i++) step();
    total++; if (outQ.size() < 3) begin bad++; $display("FAIL idle_count got=%0d exp>=3", outQ.size()); end
    for (int k = 0; k < outQ.size() && k < 3; k++) begin
      total++;
      if (outQ[k] !== mk(k < 2 ? 1 : 2, 0, k % 2)) begin
        bad++; $display("FAIL idle_beat%0d got=%h exp=%h", k, outQ[k], mk(k < 2 ? 1 : 2, 0, k % 2));
      end
    end
  endtask

  task automatic test_group_change();
    int sides[6] = '{1, 1, 2, 2, 2, 1};
    int pkts[6]  = '{0, 1, 0, 1, 2, 2};
    ppGroup = 32'd2; pktLen = 1; in1En = 1; in2En = 1;
    doReset();
    step();
    ppGroup = 32'd3;
    for (int i = 0; i < 6; i++) step();
    total++; if (outQ.size() !== 6) begin bad++; $display("FAIL grpchg_count got=%0d exp=6", outQ.size()); end
    for (int k = 0; k < outQ.size() && k < 6; k++) begin
      total++;
      if (outQ[k] !== mk(sides[k], pkts[k], 0)) begin
        bad++; $display("FAIL grpchg_beat%0d got=%h exp=%h", k, outQ[k], mk(sides[k], pkts[k], 0));
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    ppGroup = 32'd1; pktLen = 3; in1En = 1; in2En = 1;
    doReset();
    for (int i = 0; i < 4; i++) step();
    total++; if (pktCount !== 32'd1) begin bad++; $display("FAIL midrst_pre_count got=%0d exp=1", pktCount); end
    total++; if ({in2Valid, in2Ready, in2Beat} !== {1'b1, 1'b1, 32'd1}) begin
      bad++; $display("FAIL midrst_pre_state got=%b%b beat=%0d exp=11 beat=1", in2Valid, in2Ready, in2Beat);
    end
    #2 resetn = 1'b0;
    #1;
    total++; if ({outValid, outLast, outKeep, outData} !== '0) begin
      bad++; $display("FAIL midrst_outputs got=%h exp=0", {outValid, outLast, outKeep, outData});
    end
    total++; if (pktCount !== 32'd0) begin bad++; $display("FAIL midrst_pktcount got=%0d exp=0", pktCount); end
    total++; if ({in1Ready, in2Ready} !== 2'b10) begin bad++; $display("FAIL midrst_ready got=%b exp=10", {in1Ready, in2Ready}); end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    r2Seen = 0; prevStall = 0;
    outQ.delete();
    outCyc.delete();
    for (int i = 0; i < 3; i++) step();
    total++; if (r2Seen !== 1'b0) begin bad++; $display("FAIL midrst_in2_ready got=%b exp=0", r2Seen); end
    total++; if (outQ.size() < 1) begin bad++; $display("FAIL midrst_count got=%0d exp>=1", outQ.size()); end
    if (outQ.size() >= 1) begin
      total++; if (outQ[0] !== mk(1, 1, 0)) begin bad++; $display("FAIL midrst_first got=%h exp=%h", outQ[0], mk(1, 1, 0)); end
    end
  endtask

  initial begin
    test_reset();
    test_group_order();
    test_alternation();
    test_stall();
    test_idle_side();
    test_group_change();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
